jtag_axi_master: RTL and testbench

- AXI4-Lite master stage directly downstream of the JTAG data registers.
- Consumes the captured AXI request (address, data, strobe, direction) plus its update strobe.
- Executes one single-beat transaction on the system AXI4-Lite bus.
- Returns read data and a status code for the data registers to capture on the next DR scan.
- Request inputs arrive already synchronized into clk's domain; CDC is not part of this block.

---
 rtl/jtag_axi_master_pkg.sv | 42 ++++
 rtl/jtag_axi_master_timeout_cnt.sv | 39 +++
 rtl/jtag_axi_master.sv | 257 +++++++++++++++++++++++++
 tb/tb_jtag_axi_master.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_axi_master_pkg.sv
// -----------------------------------------------------------------------------
// jtag_axi_master_pkg
// Shared types for the JTAG-to-AXI4-Lite master stage:
//   axi_status_t     - status code returned to the JTAG data registers
//   axi_master_fsm_t - master state machine encoding
//   resp_to_status   - maps an AXI BRESP/RRESP code onto axi_status_t
//   DEFAULT_TIMEOUT_CYCLES - default abort limit for a stalled transaction
// -----------------------------------------------------------------------------
package jtag_axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PENDING = 3'd1,
        ST_OKAY    = 3'd2,
        ST_SLVERR  = 3'd3,
        ST_DECERR  = 3'd4,
        ST_TIMEOUT = 3'd5
    } axi_status_t;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4
    } axi_master_fsm_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 4096;

    // EXOKAY has no meaning for a single-beat AXI4-Lite access, so it folds into OKAY.
    function automatic axi_status_t resp_to_status(input logic [1:0] resp);
        axi_status_t st;
        case (resp)
            2'b00, 2'b01: st = ST_OKAY;
            2'b10:        st = ST_SLVERR;
            2'b11:        st = ST_DECERR;
            default:      st = ST_DECERR;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/jtag_axi_master_timeout_cnt.sv
// -----------------------------------------------------------------------------
// axi_timeout_cnt
// Watchdog for a bus state machine. Counts cycles while enabled and no
// progress is reported; expire fires on the LIMIT-th consecutive idle cycle.
//   clk, rstn : clock, synchronous active-low reset
//   enable    : count only while 1 (counter held at zero otherwise)
//   clear     : progress seen this cycle, restart the count
//   expire    : combinational, the current cycle is the LIMIT-th without progress
// LIMIT = 0 disables the watchdog entirely.
// -----------------------------------------------------------------------------
module axi_timeout_cnt #(
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] cnt_r;

    assign expire = (LIMIT != 0) && enable && !clear && (cnt_r == LAST);

    // Idle-cycle counter; restarts on progress, when disabled and after expiry.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (!enable || clear || expire) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

endmodule

// File: rtl/jtag_axi_master.sv
// -----------------------------------------------------------------------------
// jtag_axi_master
// Executes one single-beat AXI4-Lite transaction per request captured by the
// JTAG data registers and reports read data plus a status code back.
//   clk, rstn        : system clock, synchronous active-low reset
//   req_valid        : one-cycle request strobe (already in clk domain)
//   req_write        : 1 = write, 0 = read
//   req_addr/wdata/wstrb : request fields, latched on an accepted req_valid
//   busy             : transaction in flight
//   req_drop         : one-cycle pulse when a request arrives while busy
//   resp_rdata       : data of the last completed read
//   resp_status      : axi_status_t of the last transaction
//   m_aw*/m_w*/m_b*/m_ar*/m_r* : AXI4-Lite master channels (prot tied to 0)
// -----------------------------------------------------------------------------
module jtag_axi_master
    import jtag_axi_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    busy,
    output logic                    req_drop,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic [2:0]              resp_status,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    axi_master_fsm_t           state_r, state_next_s;
    axi_status_t               status_r, status_next_s;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic [DATA_WIDTH-1:0]     wdata_r;
    logic [DATA_WIDTH/8-1:0]   wstrb_r;
    logic [DATA_WIDTH-1:0]     rdata_r, rdata_next_s;
    logic                      awvalid_r, awvalid_next_s;
    logic                      wvalid_r, wvalid_next_s;
    logic                      bready_r, bready_next_s;
    logic                      arvalid_r, arvalid_next_s;
    logic                      rready_r, rready_next_s;
    logic                      aw_done_r, aw_done_next_s;
    logic                      w_done_r, w_done_next_s;
    logic                      busy_r, drop_r;
    logic                      load_s;
    logic                      aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic                      progress_s, tmo_expire_s;

    assign aw_hs_s    = awvalid_r & m_awready;
    assign w_hs_s     = wvalid_r  & m_wready;
    assign b_hs_s     = bready_r  & m_bvalid;
    assign ar_hs_s    = arvalid_r & m_arready;
    assign r_hs_s     = rready_r  & m_rvalid;
    // Every exit from a non-IDLE state coincides with a handshake, so
    // "any handshake" also covers the restart on state entry.
    assign progress_s = aw_hs_s | w_hs_s | b_hs_s | ar_hs_s | r_hs_s;

    axi_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rstn   (rstn),
        .enable (state_r != S_IDLE),
        .clear  (progress_s),
        .expire (tmo_expire_s)
    );

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_next_s   = state_r;
        status_next_s  = status_r;
        rdata_next_s   = rdata_r;
        awvalid_next_s = awvalid_r;
        wvalid_next_s  = wvalid_r;
        bready_next_s  = bready_r;
        arvalid_next_s = arvalid_r;
        rready_next_s  = rready_r;
        aw_done_next_s = aw_done_r;
        w_done_next_s  = w_done_r;
        load_s         = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    load_s         = 1'b1;
                    status_next_s  = ST_PENDING;
                    aw_done_next_s = 1'b0;
                    w_done_next_s  = 1'b0;
                    if (req_write) begin
                        state_next_s   = S_WR_REQ;
                        awvalid_next_s = 1'b1;
                        wvalid_next_s  = 1'b1;
                    end else begin
                        state_next_s   = S_RD_REQ;
                        arvalid_next_s = 1'b1;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WR_REQ: begin
                // AW and W retire independently; leave once both have.
                if (aw_hs_s) begin
                    awvalid_next_s = 1'b0;
                    aw_done_next_s = 1'b1;
                end else begin
                    awvalid_next_s = awvalid_r;
                end
                if (w_hs_s) begin
                    wvalid_next_s = 1'b0;
                    w_done_next_s = 1'b1;
                end else begin
                    wvalid_next_s = wvalid_r;
                end
                if ((aw_done_r | aw_hs_s) && (w_done_r | w_hs_s)) begin
                    state_next_s  = S_WR_RESP;
                    bready_next_s = 1'b1;
                end else begin
                    state_next_s = S_WR_REQ;
                end
            end
            S_WR_RESP: begin
                if (b_hs_s) begin
                    status_next_s = resp_to_status(m_bresp);
                    bready_next_s = 1'b0;
                    state_next_s  = S_IDLE;
                end else begin
                    state_next_s = S_WR_RESP;
                end
            end
            S_RD_REQ: begin
                if (ar_hs_s) begin
                    arvalid_next_s = 1'b0;
                    rready_next_s  = 1'b1;
                    state_next_s   = S_RD_RESP;
                end else begin
                    state_next_s = S_RD_REQ;
                end
            end
            S_RD_RESP: begin
                if (r_hs_s) begin
                    rdata_next_s  = m_rdata;
                    status_next_s = resp_to_status(m_rresp);
                    rready_next_s = 1'b0;
                    state_next_s  = S_IDLE;
                end else begin
                    state_next_s = S_RD_RESP;
                end
            end
            default: begin
                state_next_s   = S_IDLE;
                awvalid_next_s = 1'b0;
                wvalid_next_s  = 1'b0;
                bready_next_s  = 1'b0;
                arvalid_next_s = 1'b0;
                rready_next_s  = 1'b0;
            end
        endcase

        // Recovery path: abandon the transaction, the bus may be left mid-handshake.
        if (tmo_expire_s) begin
            state_next_s   = S_IDLE;
            status_next_s  = ST_TIMEOUT;
            awvalid_next_s = 1'b0;
            wvalid_next_s  = 1'b0;
            bready_next_s  = 1'b0;
            arvalid_next_s = 1'b0;
            rready_next_s  = 1'b0;
        end else begin
            status_next_s = status_next_s;
        end
    end

    // State, channel controls, latched request and response registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r   <= S_IDLE;
            status_r  <= ST_IDLE;
            rdata_r   <= '0;
            addr_r    <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            busy_r    <= 1'b0;
            drop_r    <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            status_r  <= status_next_s;
            rdata_r   <= rdata_next_s;
            awvalid_r <= awvalid_next_s;
            wvalid_r  <= wvalid_next_s;
            bready_r  <= bready_next_s;
            arvalid_r <= arvalid_next_s;
            rready_r  <= rready_next_s;
            aw_done_r <= aw_done_next_s;
            w_done_r  <= w_done_next_s;
            busy_r    <= (state_next_s != S_IDLE);
            // A request in the cycle that returns to IDLE still sees a busy state.
            drop_r    <= req_valid && (state_r != S_IDLE);
            if (load_s) begin
                addr_r  <= req_addr;
                wdata_r <= req_wdata;
                wstrb_r <= req_wstrb;
            end else begin
                addr_r  <= addr_r;
                wdata_r <= wdata_r;
                wstrb_r <= wstrb_r;
            end
        end
    end

    assign busy        = busy_r;
    assign req_drop    = drop_r;
    assign resp_rdata  = rdata_r;
    assign resp_status = status_r;
    assign m_awaddr    = addr_r;
    assign m_araddr    = addr_r;
    assign m_awprot    = 3'b000;
    assign m_arprot    = 3'b000;
    assign m_awvalid   = awvalid_r;
    assign m_wdata     = wdata_r;
    assign m_wstrb     = wstrb_r;
    assign m_wvalid    = wvalid_r;
    assign m_bready    = bready_r;
    assign m_arvalid   = arvalid_r;
    assign m_rready    = rready_r;

endmodule

// File: tb/tb_jtag_axi_master.sv
// -----------------------------------------------------------------------------
// tb_jtag_axi_master
// Directed bench for jtag_axi_master with a small configurable AXI4-Lite slave
// (per-channel ready delays, response delays, response codes).
// -----------------------------------------------------------------------------
module tb_jtag_axi_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        busy, req_drop;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_status;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready;
    logic [1:0]  m_bresp, m_rresp;
    logic        m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    // slave configuration, written only by the stimulus block
    int          aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0;
    logic        ar_never = 1'b0;
    logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
    logic [31:0] rdata_val = 32'h0;

    // slave state, written only by the slave process
    int          aw_wait, w_wait, b_wait, r_wait, aw_hs_cnt, b_hs_cnt;
    logic        aw_seen, w_seen, b_pend, r_pend;
    logic        a_now, w_now;
    logic [31:0] awaddr_seen, wdata_seen;
    logic [3:0]  wstrb_seen;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jtag_axi_master #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk (clk), .rstn (rstn),
        .req_valid (req_valid), .req_write (req_write), .req_addr (req_addr),
        .req_wdata (req_wdata), .req_wstrb (req_wstrb),
        .busy (busy), .req_drop (req_drop), .resp_rdata (resp_rdata), .resp_status (resp_status),
        .m_awaddr (m_awaddr), .m_awprot (m_awprot), .m_awvalid (m_awvalid), .m_awready (m_awready),
        .m_wdata (m_wdata), .m_wstrb (m_wstrb), .m_wvalid (m_wvalid), .m_wready (m_wready),
        .m_bresp (m_bresp), .m_bvalid (m_bvalid), .m_bready (m_bready),
        .m_araddr (m_araddr), .m_arprot (m_arprot), .m_arvalid (m_arvalid), .m_arready (m_arready),
        .m_rdata (m_rdata), .m_rresp (m_rresp), .m_rvalid (m_rvalid), .m_rready (m_rready)
    );

    assign m_awready = m_awvalid && (aw_wait >= aw_delay);
    assign m_wready  = m_wvalid && (w_wait >= w_delay);
    assign m_arready = m_arvalid && !ar_never;
    assign m_bresp   = bresp_val;
    assign m_rresp   = rresp_val;
    assign m_rdata   = rdata_val;
    assign a_now     = aw_seen | (m_awvalid & m_awready);
    assign w_now     = w_seen  | (m_wvalid & m_wready);

    // Slave model: ready delays, one B per AW+W pair, one R per AR.
    always @(posedge clk) begin
        if (!rstn) begin
            aw_wait <= 0; w_wait <= 0; b_wait <= 0; r_wait <= 0;
            aw_hs_cnt <= 0; b_hs_cnt <= 0;
            aw_seen <= 1'b0; w_seen <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            m_bvalid <= 1'b0; m_rvalid <= 1'b0;
            awaddr_seen <= 32'h0; wdata_seen <= 32'h0; wstrb_seen <= 4'h0;
        end else begin
            aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
            w_wait  <= (m_wvalid && !m_wready) ? w_wait + 1 : 0;
            if (m_awvalid && m_awready) begin
                aw_hs_cnt   <= aw_hs_cnt + 1;
                awaddr_seen <= m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                wdata_seen <= m_wdata;
                wstrb_seen <= m_wstrb;
            end
            if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0;
                b_hs_cnt <= b_hs_cnt + 1;
            end
            if (a_now && w_now) begin
                aw_seen <= 1'b0;
                w_seen  <= 1'b0;
                if (b_delay == 0) m_bvalid <= 1'b1;
                else begin b_pend <= 1'b1; b_wait <= b_delay; end
            end else begin
                aw_seen <= a_now;
                w_seen  <= w_now;
            end
            if (b_pend) begin
                if (b_wait <= 1) begin m_bvalid <= 1'b1; b_pend <= 1'b0; end
                else b_wait <= b_wait - 1;
            end
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                if (r_delay == 0) m_rvalid <= 1'b1;
                else begin r_pend <= 1'b1; r_wait <= r_delay; end
            end
            if (r_pend) begin
                if (r_wait <= 1) begin m_rvalid <= 1'b1; r_pend <= 1'b0; end
                else r_wait <= r_wait - 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data; req_wstrb = strb;
    endtask

    // Steps until busy falls (bounded); returns edges taken after the first one.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        if (busy) chk("wait_idle_bound", 64'(busy), 64'(0));
    endtask

    int n, base_aw, base_b;

    initial begin
        rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        step(); step();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_status", 64'(resp_status), 64'(0));
        chk("rst_rdata", 64'(resp_rdata), 64'(0));
        chk("rst_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, req_drop}), 64'(0));
        rstn = 1'b1;
        step();

        // zero-wait write
        base_aw = aw_hs_cnt;
        issue(1'b1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF);
        step(); req_valid = 1'b0;
        chk("wr_c1_busy", 64'(busy), 64'(1));
        chk("wr_c1_status", 64'(resp_status), 64'(1));
        chk("wr_c1_aw_w_valid", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
        chk("wr_awaddr", 64'(m_awaddr), 64'h1000_0040);
        chk("wr_wdata", 64'(m_wdata), 64'hDEAD_BEEF);
        chk("wr_wstrb", 64'(m_wstrb), 64'hF);
        chk("wr_prot", 64'({m_awprot, m_arprot}), 64'(0));
        step();
        chk("wr_c2_busy_bready", 64'({busy, m_bready, m_awvalid, m_wvalid}), 64'(4'b1100));
        step();
        chk("wr_c3_busy", 64'(busy), 64'(0));
        chk("wr_status", 64'(resp_status), 64'(2));
        chk("wr_aw_count", 64'(aw_hs_cnt - base_aw), 64'(1));

        // read with 5 wait cycles on R, SLVERR
        rdata_val = 32'h1234_5678; rresp_val = 2'b10; r_delay = 5;
        issue(1'b0, 32'h2000_0000, 32'h0, 4'h0);
        step(); req_valid = 1'b0;
        chk("rd_arvalid", 64'({busy, m_arvalid}), 64'(2'b11));
        chk("rd_araddr", 64'(m_araddr), 64'h2000_0000);
        wait_idle(n);
        chk("rd_latency", 64'(n), 64'(7));
        chk("rd_rdata", 64'(resp_rdata), 64'h1234_5678);
        chk("rd_status", 64'(resp_status), 64'(3));
        r_delay = 0; rresp_val = 2'b00;

        // write with W accepted 4 cycles before AW
        aw_delay = 4; base_b = b_hs_cnt;
        issue(1'b1, 32'h3000_0008, 32'hCAFE_F00D, 4'h3);
        step(); req_valid = 1'b0;
        step();
        chk("wo_w_dropped", 64'({m_awvalid, m_wvalid}), 64'(2'b10));
        step(); step(); step();
        chk("wo_aw_held", 64'({m_awvalid, m_bready}), 64'(2'b10));
        step();
        chk("wo_aw_done", 64'({m_awvalid, m_bready}), 64'(2'b01));
        step();
        chk("wo_done", 64'({busy, resp_status}), 64'({1'b0, 3'd2}));
        chk("wo_b_count", 64'(b_hs_cnt - base_b), 64'(1));
        chk("wo_seen", 64'({awaddr_seen, wstrb_seen}), 64'({32'h3000_0008, 4'h3}));
        aw_delay = 0;

        // second request while busy is dropped
        base_aw = aw_hs_cnt;
        issue(1'b1, 32'h4000_0000, 32'h1111_1111, 4'hF);
        step();
        issue(1'b1, 32'h5000_0000, 32'h2222_2222, 4'hF);
        step(); req_valid = 1'b0;
        chk("drop_pulse", 64'(req_drop), 64'(1));
        step();
        chk("drop_pulse_end", 64'({req_drop, busy, resp_status}), 64'({2'b00, 3'd2}));
        step();
        chk("drop_still_idle", 64'(busy), 64'(0));
        chk("drop_aw_count", 64'(aw_hs_cnt - base_aw), 64'(1));
        chk("drop_seen", 64'({awaddr_seen, wdata_seen}), 64'({32'h4000_0000, 32'h1111_1111}));

        // request in the cycle the FSM returns to IDLE is dropped
        rdata_val = 32'h0BAD_F00D;
        issue(1'b0, 32'h4800_0000, 32'h0, 4'h0);
        step(); req_valid = 1'b0;
        step();
        issue(1'b0, 32'h4900_0000, 32'h0, 4'h0);
        step(); req_valid = 1'b0;
        chk("edge_drop", 64'({req_drop, busy}), 64'(2'b10));
        step();
        chk("edge_no_start", 64'({busy, m_arvalid}), 64'(0));
        chk("edge_rdata", 64'(resp_rdata), 64'h0BAD_F00D);

        // AR never accepted: timeout after 16 cycles
        ar_never = 1'b1;
        issue(1'b0, 32'h6000_0000, 32'h0, 4'h0);
        step(); req_valid = 1'b0;
        n = 0;
        while (m_arvalid && n < 100) begin
            n++;
            step();
        end
        chk("tmo_ar_cycles", 64'(n), 64'(16));
        chk("tmo_status", 64'(resp_status), 64'(5));
        chk("tmo_idle", 64'({busy, m_rready}), 64'(0));
        ar_never = 1'b0;
        rdata_val = 32'hA5A5_A5A5;
        issue(1'b0, 32'h7000_0000, 32'h0, 4'h0);
        step(); req_valid = 1'b0;
        wait_idle(n);
        chk("tmo_next_latency", 64'(n), 64'(2));
        chk("tmo_next_read", 64'({resp_rdata, resp_status}), 64'({32'hA5A5_A5A5, 3'd2}));

        // reset asserted while waiting in WR_RESP
        b_delay = 6;
        issue(1'b1, 32'h8000_0000, 32'h5555_5555, 4'hF);
        step(); req_valid = 1'b0;
        step();
        chk("rst_mid_in_resp", 64'({busy, m_bready}), 64'(2'b11));
        rstn = 1'b0;
        step();
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_valids", 64'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, req_drop}), 64'(0));
        chk("rst_mid_status", 64'(resp_status), 64'(0));
        chk("rst_mid_rdata", 64'(resp_rdata), 64'(0));
        rstn = 1'b1; b_delay = 0;
        step();
        chk("rst_mid_after", 64'({busy, resp_status}), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
